ex_mem_elastic: RTL

- Parametrised EX/MEM pipeline stage for the 5-stage RISC-V core. Replaces the fixed single-register stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, and bubble-safe control gating.
- Adds a saturating back-pressure (stall) counter.
- Sits between the EX-stage ALU/forwarding outputs and the data-memory/MEM stage.

---
 rtl/ex_mem_elastic.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ex_mem_elastic.sv
// EX/MEM pipeline stage with valid/ready handshake and 2-entry skid buffer.
// Adds synchronous flush, bubble-safe control gating and a stall counter.
module ex_mem_elastic #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [RD_W-1:0]   rd_addr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [RD_W-1:0]   rd_addr_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_clr_i
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rs2;
    logic [RD_W-1:0]   rd;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  beat_t            in_b;
  beat_t            main_q;
  beat_t            main_d;
  beat_t            skid_q;
  beat_t            skid_d;
  logic [CNT_W-1:0] stall_q;

  assign in_b = '{
    ctrl: ctrl_i,
    alu:  alu_result_i,
    rs2:  rs2_data_i,
    rd:   rd_addr_i
  };

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (valid_i) begin
          main_d  = in_b;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({valid_i, ready_i})
          2'b11: main_d = in_b;
          2'b01: state_d = EMPTY;
          2'b10: begin
            skid_d  = in_b;
            state_d = FULL;
          end
          default: ;
        endcase
      end
      FULL: begin
        // skid drains into main only, so FIFO order holds
        if (ready_i) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_clr_i) begin
      stall_q <= '0;
    end else if (valid_o && !ready_i && stall_q != CNT_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign valid_o      = (state_q != EMPTY);
  assign ready_o      = (state_q != FULL);
  assign occupancy_o  = state_q;
  // bubbles must never carry RegWrite/MemWrite downstream
  assign ctrl_o       = valid_o ? main_q.ctrl : '0;
  assign alu_result_o = main_q.alu;
  assign rs2_data_o   = main_q.rs2;
  assign rd_addr_o    = main_q.rd;
  assign stall_cnt_o  = stall_q;

endmodule
